// File: rtl/layer1_sequencer.sv
// Streams one image from the image buffer into the layer-1 MAC array:
// a bias-load cycle, NUM_PIXELS read/accumulate cycles, one drain cycle, then a done pulse.
module layer1_sequencer #(
    parameter int NUM_PIXELS = 784,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [ADDR_W-1:0] img_addr,
    output logic              img_rd_en,
    input  logic [PIX_W-1:0]  img_rdata,
    output logic              l1_rst,
    output logic [ADDR_W-1:0] l1_addr,
    output logic [PIX_W-1:0]  l1_pixel
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              img_rd_en_q, img_rd_en_d;
    logic              l1_rst_q, l1_rst_d;
    logic              pix_en_q, pix_en_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d;
    logic [ADDR_W-1:0] l1_addr_q, l1_addr_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_RUN;
            S_RUN:   if (img_addr_q == LAST_ADDR) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q == S_CLEAR || state_q == S_RUN || state_q == S_DRAIN))
            state_d = S_IDLE;

        // Outputs are registered from the next state so they line up with it.
        img_addr_d = '0;
        if (state_d == S_RUN && state_q == S_RUN)
            img_addr_d = img_addr_q + 1'b1;

        // Read data lags the address by one cycle, so the weight address does too.
        l1_addr_d   = (state_d == S_RUN || state_d == S_DRAIN) ? img_addr_q : '0;
        pix_en_d    = (state_d == S_RUN && state_q == S_RUN) || state_d == S_DRAIN;
        busy_d      = state_d == S_CLEAR || state_d == S_RUN || state_d == S_DRAIN;
        done_d      = state_d == S_DONE;
        img_rd_en_d = state_d == S_RUN;
        l1_rst_d    = state_d == S_CLEAR;

        out_valid_d = out_valid_q;
        if (state_d == S_DONE)
            out_valid_d = 1'b1;
        else if (state_d == S_CLEAR || busy_q)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            img_rd_en_q <= 1'b0;
            l1_rst_q    <= 1'b0;
            pix_en_q    <= 1'b0;
            img_addr_q  <= '0;
            l1_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            img_rd_en_q <= img_rd_en_d;
            l1_rst_q    <= l1_rst_d;
            pix_en_q    <= pix_en_d;
            img_addr_q  <= img_addr_d;
            l1_addr_q   <= l1_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign img_rd_en = img_rd_en_q;
    assign l1_rst    = l1_rst_q;
    assign img_addr  = img_addr_q;
    assign l1_addr   = l1_addr_q;
    assign l1_pixel  = pix_en_q ? img_rdata : '0;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Scoreboarded bench: the driver pushes the expected output vector for every edge,
// a monitor pops and compares one vector per cycle.
module tb_layer1_sequencer;
    localparam int N = 784;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ov;
        logic       rd;
        logic       l1rst;
        logic [9:0] ia;
        logic [9:0] la;
        logic [7:0] px;
    } exp_t;

    logic       clk, rst, start, abort;
    logic       busy, done, out_valid, img_rd_en, l1_rst;
    logic [9:0] img_addr, l1_addr;
    logic [7:0] img_rdata, l1_pixel;

    logic       start_s, abort_s;
    logic       busy_s, done_s, ov_s, rd_s, l1rst_s;
    logic [9:0] ia_s, la_s;
    logic [7:0] rdata_s, px_s;

    int   ntests = 0;
    int   nfail  = 0;
    bit   mon_en = 0;
    logic [7:0] key = 8'h00;
    exp_t sbq[$];

    layer1_sequencer #(.NUM_PIXELS(N), .PIX_W(8), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .out_valid(out_valid), .img_addr(img_addr), .img_rd_en(img_rd_en),
        .img_rdata(img_rdata), .l1_rst(l1_rst), .l1_addr(l1_addr), .l1_pixel(l1_pixel));

    layer1_sequencer #(.NUM_PIXELS(4), .PIX_W(8), .ADDR_W(10)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .busy(busy_s), .done(done_s),
        .out_valid(ov_s), .img_addr(ia_s), .img_rd_en(rd_s),
        .img_rdata(rdata_s), .l1_rst(l1rst_s), .l1_addr(la_s), .l1_pixel(px_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int a);
        return 8'(a) ^ key;
    endfunction

    // Image buffer: one-cycle read latency, garbage on the bus when not reading.
    always @(posedge clk) begin
        img_rdata <= img_rd_en ? pix(int'(img_addr)) : 8'($urandom);
        rdata_s   <= 8'($urandom);
    end

    function automatic exp_t mk(input logic b, input logic d, input logic o, input logic r,
                                input logic lr, input int ia, input int la, input logic [7:0] px);
        exp_t e;
        e.busy = b; e.done = d; e.ov = o; e.rd = r; e.l1rst = lr;
        e.ia = 10'(ia); e.la = 10'(la); e.px = px;
        return e;
    endfunction

    function automatic exp_t idle(input logic o);
        return mk(0, 0, o, 0, 0, 0, 0, 8'h00);
    endfunction

    function automatic exp_t cur();
        return mk(busy, done, out_valid, img_rd_en, l1_rst, int'(img_addr), int'(l1_addr), l1_pixel);
    endfunction

    task automatic chk(input string name, input exp_t e);
        exp_t a;
        a = cur();
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h", name, a, e);
        end
    endtask

    task automatic cyc(input logic s, input logic ab, input logic r, input exp_t e);
        @(negedge clk);
        start = s; abort = ab; rst = r;
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                ntests++;
                if (sbq.size() == 0) begin
                    nfail++;
                    $display("FAIL sb_underflow at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    a = cur();
                    if (a !== e) begin
                        nfail++;
                        if (nfail <= 20)
                            $display("FAIL cycle t=%0t got b%0b d%0b v%0b r%0b c%0b ia=%0d la=%0d px=%h exp b%0b d%0b v%0b r%0b c%0b ia=%0d la=%0d px=%h",
                                     $time, a.busy, a.done, a.ov, a.rd, a.l1rst, a.ia, a.la, a.px,
                                     e.busy, e.done, e.ov, e.rd, e.l1rst, e.ia, e.la, e.px);
                    end
                end
            end
        end
    end

    // Reference trace of one inference. abort_ph: 0 none, 1 CLEAR, 2 RUN at abort_idx, 3 DRAIN.
    task automatic inference(input int abort_ph, input int abort_idx, input logic hold,
                             input logic [7:0] k, input int rst_idx);
        key = k;
        cyc(1, 1'($urandom), 0, mk(1, 0, 0, 0, 1, 0, 0, 8'h00));
        if (abort_ph == 1) begin cyc(hold, 1, 0, idle(0)); return; end
        for (int i = 0; i < N; i++) begin
            cyc(hold, 0, 0, mk(1, 0, 0, 1, 0, i, (i == 0) ? 0 : i - 1, (i == 0) ? 8'h00 : pix(i - 1)));
            if (abort_ph == 2 && i == abort_idx) begin cyc(hold, 1, 0, idle(0)); return; end
            if (i == rst_idx) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 chk("async_reset", idle(0));
                cyc(0, 0, 1, idle(0));
                cyc(0, 0, 0, idle(0));
                return;
            end
        end
        cyc(hold, 0, 0, mk(1, 0, 0, 0, 0, 0, N - 1, pix(N - 1)));
        if (abort_ph == 3) begin cyc(hold, 1, 0, idle(0)); return; end
        cyc(hold, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 8'h00));
        cyc(hold, 1'($urandom), 0, idle(1));
    endtask

    task automatic idles(input int n, input logic o);
        for (int i = 0; i < n; i++) cyc(0, 1'($urandom), 0, idle(o));
    endtask

    initial begin : driver
        logic [2:0] sm;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_s = 1'b0; abort_s = 1'b0;
        #1 chk("reset_async_t0", idle(0));
        repeat (2) @(posedge clk);
        #1 chk("reset_held", idle(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("after_reset", idle(0));

        // Small configuration: 4 pixels, done 6 edges after the start-sampling edge.
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            sm = {done_s, rd_s, (c >= 1 && c <= 4) ? (ia_s == 10'(c - 1)) : (ia_s == 10'd0)};
            ntests++;
            if (sm !== {c == 6, c >= 1 && c <= 4, 1'b1}) begin
                nfail++;
                $display("FAIL small_cfg c=%0d done=%0b rd=%0b addr=%0d", c, done_s, rd_s, ia_s);
            end
        end

        mon_en = 1;
        idles(3, 0);
        inference(0, 0, 0, 8'($urandom), -1);        // nominal
        idles(4, 1);
        inference(0, 0, 0, 8'h00, -1);               // identity image: l1_pixel == l1_addr[7:0]
        inference(0, 0, 1, 8'($urandom), -1);        // start held the whole way
        idles(2, 1);
        inference(2, 300, 0, 8'($urandom), -1);      // abort at img_addr 300
        idles(3, 0);
        inference(1, 0, 0, 8'($urandom), -1);        // abort in CLEAR
        idles(2, 0);
        inference(3, 0, 0, 8'($urandom), -1);        // abort in DRAIN
        inference(2, N - 1, 0, 8'($urandom), -1);    // abort on last RUN cycle
        idles(1, 0);
        inference(2, int'($urandom_range(0, N - 2)), 1, 8'($urandom), -1);
        idles(2, 0);
        inference(0, 0, 0, 8'($urandom), int'($urandom_range(10, N - 10)));  // async reset mid-run
        inference(0, 0, 0, 8'($urandom), -1);        // full run after reset
        idles(5, 1);

        @(posedge clk);
        #2;
        mon_en = 0;
        ntests++;
        if (sbq.size() != 0) begin
            nfail++;
            $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
